// File: rtl/result_display_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : result_display_ctrl_if
// Purpose  : Result handshake between a datapath (master) and the display
//            controller (slave).
// Signals  : Valid - datapath done level, synchronous to the display clock
//            Value - unsigned binary result, WIDTH bits
//            Busy  - display controller is converting; new results ignored
// Revision : 1.0 - initial release
// ============================================================================
interface result_display_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             Valid;
  logic [WIDTH-1:0] Value;
  logic             Busy;

  modport master (output Valid, output Value, input  Busy);
  modport slave  (input  Valid, input  Value, output Busy);
endinterface
`default_nettype wire

// File: rtl/result_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : result_display_ctrl
// Purpose  : Captures a binary result on a Valid rising edge, converts it to
//            BCD with a sequential double-dabble, and drives DIGITS registered
//            7-segment digits with leading-zero blanking and an overflow dash
//            display. Also provides a free-running Tick enable and a
//            synchronized single-cycle StartPulse for a push-button.
// Ports    : CLK, RST         - clock, asynchronous active-high reset
//            Start            - raw asynchronous push-button level
//            bus (slave)      - Valid/Value in, Busy out
//            Tick             - one-cycle enable every DIV cycles
//            StartPulse       - one pulse per synchronized Start press
//            Overflow         - last captured Value >= 10^DIGITS
//            Segs             - digit i on Segs[7i+6:7i], bit order gfedcba
// Revision : 1.0 - initial release
// ============================================================================
module result_display_ctrl #(
  parameter int WIDTH      = 16,
  parameter int DIGITS     = 4,
  parameter int DIV        = 50_000_000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  Start,
  result_display_ctrl_if.slave  bus,
  output logic                  Tick,
  output logic                  StartPulse,
  output logic                  Overflow,
  output logic [7*DIGITS-1:0]   Segs
);

  localparam int C_TW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int C_CW = $clog2(WIDTH + 1);
  localparam int C_BW = 4 * DIGITS;
  localparam logic [C_TW-1:0] C_TICK_MAX = C_TW'(DIV - 1);
  localparam logic [C_CW-1:0] C_CNT_LAST = C_CW'(WIDTH - 1);

  // Active-high gfedcba pattern for one decimal digit.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0:    p = 7'b0111111;
      4'd1:    p = 7'b0000110;
      4'd2:    p = 7'b1011011;
      4'd3:    p = 7'b1001111;
      4'd4:    p = 7'b1100110;
      4'd5:    p = 7'b1101101;
      4'd6:    p = 7'b1111101;
      4'd7:    p = 7'b0000111;
      4'd8:    p = 7'b1111111;
      4'd9:    p = 7'b1101111;
      default: p = 7'b0000000;
    endcase
    return p;
  endfunction

  // Full display image: dashes on overflow, otherwise decimal digits with
  // leading zeros blanked (digit 0 is always shown).
  function automatic logic [7*DIGITS-1:0] render(input logic [C_BW-1:0] bcd,
                                                 input logic            ovf);
    logic [7*DIGITS-1:0] s;
    logic [6:0]          p;
    logic                lead;
    s    = '0;
    lead = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (ovf) begin
        p = 7'b1000000;
      end else if (lead && (i != 0) && (bcd[4*i +: 4] == 4'd0)) begin
        p = 7'b0000000;
      end else begin
        p    = seg7(bcd[4*i +: 4]);
        lead = 1'b0;
      end
      s[7*i +: 7] = (ACTIVE_LOW != 0) ? ~p : p;
    end
    return s;
  endfunction

  localparam logic [7*DIGITS-1:0] C_SEGS_RST = render('0, 1'b0);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONVERT = 2'd1,
    S_LOAD    = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Tick generator
  // --------------------------------------------------------------------------
  logic [C_TW-1:0] tick_cnt_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tick_cnt_q <= '0;
    end else if (tick_cnt_q == C_TICK_MAX) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_q + 1'b1;
    end
  end

  assign Tick = (tick_cnt_q == C_TICK_MAX);

  // --------------------------------------------------------------------------
  // Start synchronizer and rising-edge pulse
  // --------------------------------------------------------------------------
  logic sync1_q, sync2_q, sync_prev_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      sync_prev_q <= 1'b0;
    end else begin
      sync1_q     <= Start;
      sync2_q     <= sync1_q;
      sync_prev_q <= sync2_q;
    end
  end

  // Built only from flops downstream of the synchronizer.
  assign StartPulse = sync2_q & ~sync_prev_q;

  // --------------------------------------------------------------------------
  // Capture, double-dabble conversion and display load
  // --------------------------------------------------------------------------
  state_t              state_q;
  logic                busy_q;
  logic                valid_prev_q;
  logic [WIDTH-1:0]    bin_q;
  logic [C_BW-1:0]     bcd_q;
  logic                ovf_q;
  logic [C_CW-1:0]     cnt_q;
  logic                overflow_q;
  logic [7*DIGITS-1:0] segs_q;

  logic                valid_rise_d;
  logic [C_BW-1:0]     bcd_adj_d;
  logic [C_BW-1:0]     bcd_shift_d;

  assign valid_rise_d = bus.Valid & ~valid_prev_q;

  // Add-3 correction on every digit >= 5 before the shift.
  always_comb begin
    bcd_adj_d = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj_d[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  assign bcd_shift_d = {bcd_adj_d[C_BW-2:0], bin_q[WIDTH-1]};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= S_IDLE;
      busy_q       <= 1'b0;
      valid_prev_q <= 1'b0;
      bin_q        <= '0;
      bcd_q        <= '0;
      ovf_q        <= 1'b0;
      cnt_q        <= '0;
      overflow_q   <= 1'b0;
      segs_q       <= C_SEGS_RST;
    end else begin
      valid_prev_q <= bus.Valid;
      case (state_q)
        S_IDLE: begin
          // Edges seen outside IDLE fall through here unused, so they are
          // dropped rather than queued.
          if (valid_rise_d) begin
            bin_q   <= bus.Value;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            state_q <= S_CONVERT;
            busy_q  <= 1'b1;
          end
        end
        S_CONVERT: begin
          bcd_q <= bcd_shift_d;
          bin_q <= bin_q << 1;
          // A carry out of the top digit means the value needs more digits.
          if (bcd_adj_d[C_BW-1]) begin
            ovf_q <= 1'b1;
          end
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == C_CNT_LAST) begin
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          segs_q     <= render(bcd_q, ovf_q);
          overflow_q <= ovf_q;
          state_q    <= S_IDLE;
          busy_q     <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Busy = busy_q;
  assign Overflow = overflow_q;
  assign Segs     = segs_q;

endmodule
`default_nettype wire

// File: doc/result_display_ctrl.md
RESULT_DISPLAY_CTRL -- requirements
Module: result_display_ctrl

Interface
REQ-001 The module SHALL have parameter WIDTH, default 16: bit width of the binary result input.
REQ-002 The module SHALL have parameter DIGITS, default 4: number of decimal 7-segment digits driven.
REQ-003 The module SHALL have parameter DIV, default 50_000_000: Tick period in CLK cycles, minimum 2.
REQ-004 The module SHALL have parameter ACTIVE_LOW, default 1: 1 = segment lit when bit is 0.
REQ-005 The module SHALL have port CLK, input, 1 bit: single clock, all state on the rising edge.
REQ-006 The module SHALL have port RST, input, 1 bit: reset, asynchronous and active-high.
REQ-007 The module SHALL have port Start, input, 1 bit: raw, asynchronous push-button level.
REQ-008 The module SHALL have port Valid, input, 1 bit: datapath done level, synchronous to CLK.
REQ-009 The module SHALL have port Value, input, WIDTH bits: unsigned binary result to display.
REQ-010 The module SHALL have port Tick, output, 1 bit: one-cycle enable, once every DIV cycles.
REQ-011 The module SHALL have port StartPulse, output, 1 bit: single-cycle pulse per Start press.
REQ-012 The module SHALL have port Busy, output, 1 bit: conversion in progress.
REQ-013 The module SHALL have port Overflow, output, 1 bit: last captured Value >= 10^DIGITS.
REQ-014 The module SHALL have port Segs, output, 7*DIGITS bits: digit i on Segs[7i+6:7i], bit order gfedcba, digit 0 least significant.

Function
REQ-015 The Tick counter SHALL count 0..DIV-1 and wrap to 0; Tick SHALL be 1 exactly in the cycle the count equals DIV-1.
REQ-016 Start SHALL pass through a 2-FF synchronizer; StartPulse SHALL be 1 for one cycle on a synchronized 0->1 transition; holding Start high SHALL give no further pulses.
REQ-017 A Valid rising edge SHALL be detected as Valid high with the registered previous Valid low.
REQ-018 The FSM SHALL have states IDLE, CONVERT and LOAD.
REQ-019 IDLE -> CONVERT SHALL occur on a Valid rising edge; the transition captures Value and clears the BCD register and the overflow flag.
REQ-020 CONVERT SHALL run exactly WIDTH cycles of shift-add-3 (double dabble) on a 4*DIGITS-bit BCD register.
REQ-021 Any 1 bit shifted out of the top BCD digit during CONVERT SHALL set a sticky overflow flag.
REQ-022 LOAD SHALL last one cycle, copy the BCD register and the overflow flag to the display registers, then return to IDLE.
REQ-023 Busy SHALL be 1 exactly while the FSM is in CONVERT or LOAD.
REQ-024 Segs and Overflow SHALL update, and Busy SHALL fall, WIDTH+2 cycles after the cycle in which the Valid edge is sampled.
REQ-025 A Valid rising edge occurring while Busy is 1 SHALL be ignored; it SHALL not be queued.
REQ-026 Overflow=1 SHALL display every digit as a dash (segment g only).
REQ-027 Leading zero digits SHALL be blank, except that digit 0 SHALL always be shown, so a value of 0 displays "0".
REQ-028 Decoding SHALL use standard hex-free 0-9 patterns; ACTIVE_LOW=1 SHALL invert every segment bit.
REQ-029 Segs SHALL be driven from registers only, with no glitching path from Value.

Reset
REQ-030 While RST is 1: Tick counter=0, Tick=0, synchronizers=0, StartPulse=0, previous Valid=0, state=IDLE, Busy=0, Overflow=0, display BCD=0.
REQ-031 With the defaults, Segs after reset SHALL equal {7'b1111111 x3, 7'b1000000}: digit 0 shows "0", all other digits blank.
REQ-032 Reset asserted during CONVERT SHALL abort the conversion with no LOAD; the first Valid edge after release SHALL convert normally.

Verification (WIDTH=16, DIGITS=4, DIV=4, ACTIVE_LOW=1)
REQ-033 Release reset, run 20 cycles -> Tick=1 on cycles 3, 7, 11, 15, 19 only.
REQ-034 Value=1234 with a Valid edge -> Busy=1 for 17 cycles; 18 cycles later Segs digits 3..0 = 1111001, 0100100, 0110000, 0011001; Overflow=0.
REQ-035 Value=7 -> digit 0 = 1111000, digits 1..3 = 1111111; Value=12345 -> Overflow=1, all digits 0111111.
REQ-036 Start held high 10 cycles then released -> exactly one StartPulse, 2-3 cycles after the rise.
REQ-037 A second Valid edge (Value=99) 5 cycles into a conversion of 1234 -> ignored; display shows 1234.
REQ-038 RST pulsed 8 cycles into a conversion -> Busy=0 and display "0"; then Value=42 -> "42" with digits 3..2 blank.
